// File: rtl/qos_dispatcher.sv
// qos_dispatcher: strict-priority packet buffer drain with priority-replace on overflow
module qos_dispatcher #(
  parameter int DEPTH = 6,
  parameter int PW    = 2
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [PW-1:0] in_packet,
  input  logic          out_req,
  output logic          out_valid,
  output logic [PW-1:0] outputted_packet,
  output logic [11:0]   transmitted,
  output logic [11:0]   dropped,
  output logic [3:0]    current,
  output logic          empty,
  output logic          full
);
  logic          run;
  logic [PW-1:0] mem [DEPTH];
  logic [PW-1:0] mid [DEPTH];
  logic [PW-1:0] nxt [DEPTH];
  logic [PW-1:0] max_v, min_v;
  logic [3:0]    max_i, min_i, cnt1, cnt_n;
  logic          pop, push, drop;
  assign empty = current == 4'd0;
  assign full  = current == 4'(DEPTH);
  // next slot contents: pop the oldest maximum, then append or replace the oldest minimum
  always_comb begin
    pop = run && out_req && current != 4'd0;
    max_v = '0;
    max_i = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (4'(i) < current && mem[i] >= max_v) begin
        max_v = mem[i];
        max_i = 4'(i);
      end
    for (int i = 0; i < DEPTH - 1; i++) mid[i] = (pop && 4'(i) >= max_i) ? mem[i+1] : mem[i];
    mid[DEPTH-1] = pop ? '0 : mem[DEPTH-1];
    cnt1 = pop ? current - 4'd1 : current;
    min_v = '1;
    min_i = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (4'(i) < cnt1 && mid[i] <= min_v) begin
        min_v = mid[i];
        min_i = 4'(i);
      end
    push = run && in_valid;
    drop = push && cnt1 == 4'(DEPTH);
    nxt = mid;
    cnt_n = cnt1;
    if (push && !drop) begin
      for (int i = 0; i < DEPTH; i++) if (4'(i) == cnt1) nxt[i] = in_packet;
      cnt_n = cnt1 + 4'd1;
    end else if (drop && in_packet > min_v) begin
      for (int i = 0; i < DEPTH - 1; i++) if (4'(i) >= min_i) nxt[i] = mid[i+1];
      nxt[DEPTH-1] = in_packet;
    end
  end
  // state update; run holds off operation until the first edge after reset release
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      run <= 1'b0;
      out_valid <= 1'b0;
      outputted_packet <= '0;
      transmitted <= '0;
      dropped <= '0;
      current <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      run <= 1'b1;
      out_valid <= pop;
      if (pop) outputted_packet <= max_v;
      if (pop) transmitted <= transmitted + 12'd1;
      if (drop) dropped <= dropped + 12'd1;
      current <= cnt_n;
      mem <= nxt;
    end
endmodule

// File: tb/tb_qos_dispatcher.sv
// tb_qos_dispatcher: randomized and directed scoreboard bench for qos_dispatcher
module tb_qos_dispatcher;
  localparam int DEPTH = 6;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [1:0] in_packet = '0;
  logic out_req = 1'b0;
  logic out_valid;
  logic [1:0] outputted_packet;
  logic [11:0] transmitted, dropped;
  logic [3:0] current;
  logic empty, full;
  int checks = 0;
  int failures = 0;
  int q[$];
  int expq[$];
  int m_tx = 0, m_drop = 0, m_out = 0;
  bit m_run = 0, m_ov = 0;

  qos_dispatcher #(.DEPTH(DEPTH), .PW(2)) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_packet(in_packet),
    .out_req(out_req), .out_valid(out_valid), .outputted_packet(outputted_packet),
    .transmitted(transmitted), .dropped(dropped), .current(current),
    .empty(empty), .full(full)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock)
    if (rst_n && out_valid) begin
      if (expq.size() == 0) chk("unexpected_release", 1, 0);
      else chk("pop_value", int'(outputted_packet), expq.pop_front());
    end

  task automatic check_state();
    chk("current", int'(current), q.size());
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("full", int'(full), int'(q.size() == DEPTH));
    chk("transmitted", int'(transmitted), m_tx);
    chk("dropped", int'(dropped), m_drop);
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("outputted_packet", int'(outputted_packet), m_out);
  endtask

  task automatic cyc(input bit v, input int p, input bit r);
    int bi, best;
    in_valid = v;
    in_packet = 2'(p);
    out_req = r;
    m_ov = 0;
    if (!m_run) m_run = 1;
    else begin
      if (r && q.size() > 0) begin
        best = -1; bi = 0;
        foreach (q[i]) if (q[i] > best) begin best = q[i]; bi = i; end
        q.delete(bi);
        expq.push_back(best);
        m_out = best;
        m_ov = 1;
        m_tx = (m_tx + 1) % 4096;
      end
      if (v) begin
        if (q.size() < DEPTH) q.push_back(p);
        else begin
          best = 4; bi = 0;
          foreach (q[i]) if (q[i] < best) begin best = q[i]; bi = i; end
          if (p > best) begin q.delete(bi); q.push_back(p); end
          m_drop = (m_drop + 1) % 4096;
        end
      end
    end
    @(negedge clock);
    check_state();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    q.delete(); expq.delete();
    m_tx = 0; m_drop = 0; m_out = 0; m_ov = 0; m_run = 0;
    check_state();
    in_valid = 0; out_req = 0;
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  initial begin
    int seq1[6] = '{1, 0, 3, 2, 3, 1};
    int seq2[6] = '{0, 1, 0, 2, 1, 2};
    @(negedge clock);
    do_reset();
    cyc(0, 0, 0);
    foreach (seq1[i]) cyc(1, seq1[i], 0);
    repeat (6) cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 1);
    foreach (seq2[i]) cyc(1, seq2[i], 0);
    cyc(1, 3, 0);
    cyc(1, 0, 0);
    repeat (6) cyc(0, 0, 1);
    repeat (6) cyc(1, 1, 0);
    cyc(1, 2, 1);
    repeat (6) cyc(0, 0, 1);
    do_reset();
    cyc(0, 0, 0);
    repeat (4096) begin
      cyc(1, $urandom_range(0, 3), 0);
      cyc(0, 0, 1);
    end
    repeat (6) cyc(1, 3, 0);
    repeat (4096) cyc(1, $urandom_range(0, 3), 0);
    repeat (6) cyc(0, 0, 1);
    repeat (3000) cyc(bit'($urandom_range(0, 1)), $urandom_range(0, 3), bit'($urandom_range(0, 2) == 0));
    repeat (2000) cyc(bit'($urandom_range(0, 2) == 0), $urandom_range(0, 3), bit'($urandom_range(0, 1)));
    do_reset();
    cyc(0, 0, 0);
    repeat (4) cyc(1, $urandom_range(0, 3), 0);
    do_reset();
    cyc(1, 3, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    #1;
    chk("scoreboard_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
